// File: rtl/loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------+
// | loader_pkg - sizes and FSM state encoding for array_loader |
// | Rev 1.0                                                    |
// +------------------------------------------------------------+
package loader_pkg;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int MAX_N  = (1 << ADDR_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage
`default_nettype wire

// File: rtl/array_ram.sv
`default_nettype none
// +------------------------------------------------------------+
// | array_ram - 1R1W synchronous RAM, registered read port     |
// | Rev 1.0                                                    |
// +------------------------------------------------------------+
module array_ram
   import loader_pkg::*;
#(
   parameter int ADDR_W = loader_pkg::ADDR_W,
   parameter int DATA_W = loader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is never reset; a same-address read in the write cycle sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/array_loader.sv
`default_nettype none
// +------------------------------------------------------------+
// | array_loader - streams an array into RAM, runs the kernel, |
// | returns its result. Rev 1.0                                |
// +------------------------------------------------------------+
module array_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = loader_pkg::ADDR_W,
   parameter int DATA_W = loader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              k_start,
   input  logic              k_finish,
   output logic [ADDR_W-1:0] k_n,
   input  logic [DATA_W-1:0] k_res,
   input  logic              arr_read_en,
   input  logic [ADDR_W-1:0] arr_read_addr_arg,
   output logic [DATA_W-1:0] arr_read_val_ret,
   input  logic              arr_write_en,
   input  logic [ADDR_W-1:0] arr_write_addr_arg,
   input  logic [DATA_W-1:0] arr_write_val_arg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_res,
   output logic [ADDR_W-1:0] out_n,
   output logic              busy
);
   localparam logic [ADDR_W-1:0] C_MAX_N = '1;

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] count_q,   count_d;
   logic              k_start_q, k_start_d;
   logic [ADDR_W-1:0] k_n_q,     k_n_d;
   logic [DATA_W-1:0] out_res_q, out_res_d;
   logic [ADDR_W-1:0] out_n_q,   out_n_d;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      k_start_d = 1'b0;
      k_n_d     = k_n_q;
      out_res_d = out_res_q;
      out_n_d   = out_n_q;
      in_ready  = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = in_data;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en   = 1'b1;
               count_d = ADDR_W'(1);
               if (in_last) begin
                  state_d   = ST_RUN;
                  k_start_d = 1'b1;
                  k_n_d     = count_d;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en   = 1'b1;
               wr_addr = count_q;
               count_d = count_q + 1'b1;
               // Reaching the last addressable slot ends the load, so count never wraps.
               if (in_last || count_d == C_MAX_N) begin
                  state_d   = ST_RUN;
                  k_start_d = 1'b1;
                  k_n_d     = count_d;
               end
            end
         end
         ST_RUN: begin
            wr_en   = arr_write_en;
            wr_addr = arr_write_addr_arg;
            wr_data = arr_write_val_arg;
            if (k_finish && !k_start_q) begin
               out_res_d = k_res;
               out_n_d   = count_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         k_start_q <= 1'b0;
         k_n_q     <= '0;
         out_res_q <= '0;
         out_n_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         k_start_q <= k_start_d;
         k_n_q     <= k_n_d;
         out_res_q <= out_res_d;
         out_n_q   <= out_n_d;
      end
   end

   array_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (arr_read_en),
      .rd_addr (arr_read_addr_arg),
      .rd_data (arr_read_val_ret),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   assign k_start   = k_start_q;
   assign k_n       = k_n_q;
   assign out_res   = out_res_q;
   assign out_n     = out_n_q;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_array_loader.sv
`default_nettype none
// +------------------------------------------------------------+
// | tb_array_loader - scoreboard bench for array_loader        |
// | Rev 1.0                                                    |
// +------------------------------------------------------------+
module tb_array_loader;
   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] res;
      logic [AW-1:0] n;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last;
   logic [DW-1:0] in_data;
   logic          k_start, k_finish;
   logic [AW-1:0] k_n;
   logic [DW-1:0] k_res;
   logic          arr_read_en;
   logic [AW-1:0] arr_read_addr_arg;
   logic [DW-1:0] arr_read_val_ret;
   logic          arr_write_en;
   logic [AW-1:0] arr_write_addr_arg;
   logic [DW-1:0] arr_write_val_arg;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_res;
   logic [AW-1:0] out_n;
   logic          busy;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   array_loader dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_data            (in_data),
      .in_last            (in_last),
      .k_start            (k_start),
      .k_finish           (k_finish),
      .k_n                (k_n),
      .k_res              (k_res),
      .arr_read_en        (arr_read_en),
      .arr_read_addr_arg  (arr_read_addr_arg),
      .arr_read_val_ret   (arr_read_val_ret),
      .arr_write_en       (arr_write_en),
      .arr_write_addr_arg (arr_write_addr_arg),
      .arr_write_val_arg  (arr_write_val_arg),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_res            (out_res),
      .out_n              (out_n),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Result monitor: every output handshake is matched against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got out_res 0x%0h with no result expected", out_res);
         end else begin
            e = sb.pop_front();
            chk("out_res", out_res, e.res);
            chk("out_n", 32'(out_n), 32'(e.n));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic last, input logic check_ready);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      if (check_ready) chk("in_ready_load", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_kstart(input int n);
      int cyc = 0;
      while (!k_start && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("k_start_seen", 32'(k_start), 32'd1);
      chk("k_n", 32'(k_n), 32'(n));
      tick();
      chk("k_start_one_cycle", 32'(k_start), 32'd0);
   endtask

   task automatic rd(input int a, output logic [DW-1:0] v);
      arr_read_en       = 1'b1;
      arr_read_addr_arg = AW'(a);
      tick();
      arr_read_en = 1'b0;
      v = arr_read_val_ret;
   endtask

   task automatic kernel_sum(input int n, output logic [DW-1:0] s);
      logic [DW-1:0] v;
      s = '0;
      for (int i = 0; i < n; i++) begin
         rd(i, v);
         s = s + v;
      end
   endtask

   task automatic finish_kernel(input logic [DW-1:0] r);
      k_finish = 1'b1;
      k_res    = r;
      tick();
      k_finish = 1'b0;
      k_res    = '0;
   endtask

   task automatic handshake();
      chk("out_valid_done", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("busy_after_hs", 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] s;
      logic [DW-1:0] v;
      rst = 1'b1; in_valid = 0; in_last = 0; in_data = '0;
      k_finish = 0; k_res = '0; arr_read_en = 0; arr_read_addr_arg = '0;
      arr_write_en = 0; arr_write_addr_arg = '0; arr_write_val_arg = '0; out_ready = 0;
      tick(); tick();
      chk("rst_k_start", 32'(k_start), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_res", out_res, 32'd0);
      chk("rst_out_n", 32'(out_n), 32'd0);
      chk("rst_k_n", 32'(k_n), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_val", arr_read_val_ret, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();

      // Four-element array, then result held in DONE with a competing beat waiting.
      sb.push_back('{res: 32'd10, n: 10'd4});
      send(32'd1, 1'b0, 1'b1); send(32'd2, 1'b0, 1'b1);
      send(32'd3, 1'b0, 1'b1); send(32'd4, 1'b1, 1'b1);
      wait_kstart(4);
      kernel_sum(4, s);
      finish_kernel(s);
      in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("done_out_valid", 32'(out_valid), 32'd1);
         chk("done_out_res", out_res, 32'd10);
         chk("done_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      sb.push_back('{res: 32'd99, n: 10'd1});
      handshake();
      chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      wait_kstart(1);
      kernel_sum(1, s);
      finish_kernel(s);
      handshake();

      // Single-beat array straight from IDLE.
      sb.push_back('{res: 32'd7, n: 10'd1});
      send(32'd7, 1'b1, 1'b1);
      wait_kstart(1);
      kernel_sum(1, s);
      finish_kernel(s);
      handshake();

      // Full-depth array without in_last; extra beats during RUN must be refused.
      sb.push_back('{res: 32'd523776, n: 10'd1023});
      for (int i = 0; i < 1023; i++) send(32'(i + 1), 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 32'hBAD;
      chk("in_ready_full", 32'(in_ready), 32'd0);
      wait_kstart(1023);
      in_valid = 1'b0;
      kernel_sum(1023, s);
      finish_kernel(s);
      handshake();

      // Kernel read/write collision on address 3, then a write attempt outside RUN.
      sb.push_back('{res: 32'd57065, n: 10'd4});
      send(32'd10, 1'b0, 1'b1); send(32'd20, 1'b0, 1'b1);
      send(32'd30, 1'b0, 1'b1); send(32'd40, 1'b1, 1'b1);
      wait_kstart(4);
      arr_write_en = 1'b1; arr_write_addr_arg = 10'd3; arr_write_val_arg = 32'hDEAD;
      rd(3, v);
      arr_write_en = 1'b0;
      chk("rw_same_old", v, 32'd40);
      rd(3, v);
      chk("rw_next_new", v, 32'hDEAD);
      kernel_sum(4, s);
      finish_kernel(s);
      arr_write_en = 1'b1; arr_write_addr_arg = 10'd1; arr_write_val_arg = 32'hBEEF;
      tick();
      arr_write_en = 1'b0;
      rd(1, v);
      chk("write_outside_run", v, 32'd20);
      handshake();

      // Reset in the middle of RUN abandons the job but keeps the RAM.
      send(32'd5, 1'b0, 1'b1); send(32'd6, 1'b0, 1'b1); send(32'd7, 1'b1, 1'b1);
      wait_kstart(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      k_finish = 1'b1; k_res = 32'd123;
      tick();
      k_finish = 1'b0;
      tick();
      chk("midrun_busy", 32'(busy), 32'd0);
      chk("midrun_out_valid", 32'(out_valid), 32'd0);
      chk("midrun_out_res", out_res, 32'd0);
      chk("midrun_in_ready", 32'(in_ready), 32'd1);
      rd(0, v); chk("mem_keep0", v, 32'd5);
      rd(1, v); chk("mem_keep1", v, 32'd6);
      rd(2, v); chk("mem_keep2", v, 32'd7);

      tick(); tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
